// File: rtl/dcache_2way_wb.sv
// rtl/dcache_2way_wb.sv - 2-way set-associative write-back, write-allocate data cache with flush.
// Define DCACHE_LRU_EN for per-set LRU victims; otherwise a global round-robin bit picks the victim.
module dcache_2way_wb #(
   parameter int INDEX_W = 5,
   parameter int LINE_W  = 256,
   parameter int ADDR_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [31:0]       p1_data_i,
   input  logic              p1_MemRead_i,
   input  logic              p1_MemWrite_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   input  logic              flush_i,
   output logic              flush_busy_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);
   localparam int SETS   = 2**INDEX_W;
   localparam int OFF_W  = $clog2(LINE_W/8);
   localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
   localparam int WORD_W = OFF_W - 2;
   localparam int CNT_W  = INDEX_W + 2;
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(2 * SETS);

   typedef enum logic [2:0] {S_IDLE, S_VICTIM, S_WB, S_REFILL, S_FLUSH, S_FWB} state_t;
   state_t state_q, state_d;

   logic [SETS-1:0]   valid_q [2];
   logic [SETS-1:0]   dirty_q [2];
   logic [TAG_W-1:0]  tag_q   [2][SETS];
   logic [LINE_W-1:0] line_q  [2][SETS];

   logic               vway_q;
   logic [TAG_W-1:0]   vtag_q, rtag_q;
   logic [INDEX_W-1:0] set_q;
   logic [CNT_W-1:0]   cnt_q;
`ifdef DCACHE_LRU_EN
   logic [SETS-1:0]    lru_q;
`else
   logic               rr_q;
`endif

   logic               req, hit, hit_way, victim, policy_way, fl_way, fl_dirty;
   logic [1:0]         match;
   logic [INDEX_W-1:0] req_set, fl_set;
   logic [TAG_W-1:0]   req_tag;
   logic [WORD_W-1:0]  req_word;
   logic [LINE_W-1:0]  rd_line;
   logic               unused_addr_lsb;

   assign req      = p1_MemRead_i | p1_MemWrite_i;
   assign req_set  = p1_addr_i[OFF_W+INDEX_W-1:OFF_W];
   assign req_tag  = p1_addr_i[ADDR_W-1:OFF_W+INDEX_W];
   assign req_word = p1_addr_i[OFF_W-1:2];
   assign unused_addr_lsb = &{1'b0, p1_addr_i[1:0]};

   always_comb begin
      match = '0;
      for (int w = 0; w < 2; w++)
         match[w] = valid_q[w][req_set] && (tag_q[w][req_set] == req_tag);
   end

   assign hit     = req & (|match);
   assign hit_way = match[1];
   assign rd_line = line_q[hit_way][req_set];

   assign p1_data_o    = (p1_MemRead_i && hit) ? rd_line[{req_word, 5'b0} +: 32] : 32'h0;
   assign p1_stall_o   = (req & ~hit) | (state_q != S_IDLE);
   assign flush_busy_o = (state_q == S_FLUSH) || (state_q == S_FWB);

`ifdef DCACHE_LRU_EN
   assign policy_way = lru_q[req_set];
`else
   assign policy_way = rr_q;
`endif
   // An empty way always wins over the replacement policy.
   assign victim = !valid_q[0][req_set] ? 1'b0 :
                   !valid_q[1][req_set] ? 1'b1 : policy_way;

   // Flush walk order: set-major, way-minor.
   assign fl_way   = cnt_q[0];
   assign fl_set   = cnt_q[INDEX_W:1];
   assign fl_dirty = valid_q[fl_way][fl_set] & dirty_q[fl_way][fl_set];

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req && !hit)            state_d = S_VICTIM;
            else if (flush_i && !req)   state_d = S_FLUSH;
         end
         S_VICTIM: state_d = (valid_q[victim][req_set] && dirty_q[victim][req_set]) ? S_WB : S_REFILL;
         S_WB:     if (mem_ack_i) state_d = S_REFILL;
         S_REFILL: if (mem_ack_i) state_d = S_IDLE;
         S_FLUSH: begin
            if (cnt_q == CNT_END) state_d = S_IDLE;
            else if (fl_dirty)    state_d = S_FWB;
         end
         S_FWB:    if (mem_ack_i) state_d = S_FLUSH;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (state_q)
         S_WB: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {vtag_q, set_q, {OFF_W{1'b0}}};
            mem_data_o   = line_q[vway_q][set_q];
         end
         S_REFILL: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {rtag_q, set_q, {OFF_W{1'b0}}};
         end
         S_FWB: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tag_q[fl_way][fl_set], fl_set, {OFF_W{1'b0}}};
            mem_data_o   = line_q[fl_way][fl_set];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         dirty_q[0] <= '0;
         dirty_q[1] <= '0;
         cnt_q      <= '0;
`ifdef DCACHE_LRU_EN
         lru_q      <= '0;
`else
         rr_q       <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (hit) begin
               if (p1_MemWrite_i) dirty_q[hit_way][req_set] <= 1'b1;
`ifdef DCACHE_LRU_EN
               lru_q[req_set] <= ~hit_way;
`endif
            end
            S_WB: if (mem_ack_i) dirty_q[vway_q][set_q] <= 1'b0;
            S_REFILL: if (mem_ack_i) begin
               valid_q[vway_q][set_q] <= 1'b1;
               dirty_q[vway_q][set_q] <= 1'b0;
`ifdef DCACHE_LRU_EN
               lru_q[set_q] <= ~vway_q;
`else
               rr_q <= ~rr_q;
`endif
            end
            S_FLUSH: begin
               if (cnt_q == CNT_END) cnt_q <= '0;
               else if (!fl_dirty)   cnt_q <= cnt_q + CNT_W'(1);
            end
            S_FWB: if (mem_ack_i) begin
               dirty_q[fl_way][fl_set] <= 1'b0;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == S_VICTIM) begin
         vway_q <= victim;
         vtag_q <= tag_q[victim][req_set];
         set_q  <= req_set;
         rtag_q <= req_tag;
      end
      if (state_q == S_IDLE && hit && p1_MemWrite_i)
         line_q[hit_way][req_set][{req_word, 5'b0} +: 32] <= p1_data_i;
      if (state_q == S_REFILL && mem_ack_i) begin
         line_q[vway_q][set_q] <= mem_data_i;
         tag_q[vway_q][set_q]  <= rtag_q;
      end
   end

endmodule

// File: tb/tb_dcache_2way_wb.sv
// tb/tb_dcache_2way_wb.sv - directed and random checks of dcache_2way_wb against a set/way reference model.
module tb_dcache_2way_wb;
   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
   logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
   logic         flush_i, flush_busy_o;
   logic         mem_enable_o, mem_write_o, mem_ack_i;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i;

   dcache_2way_wb dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
      .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
      .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .flush_i(flush_i), .flush_busy_o(flush_busy_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] data;
   } xfer_t;

   int n_assert = 0;
   int n_fail   = 0;

   bit           m_valid [32][2];
   bit           m_dirty [32][2];
   logic [21:0]  m_tag   [32][2];
   logic [255:0] m_line  [32][2];
   int           m_last  [32];
   int           m_rr;
   logic [255:0] memory [logic [31:0]];
   xfer_t        exp_q [$];

   xfer_t        cur;
   bit           in_x, refill_acked;
   int           wt, seen;
   logic [31:0]  last_wb_addr;
   logic [255:0] last_wb_data;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mem_get(input logic [31:0] a);
      logic [255:0] l;
      if (memory.exists(a)) return memory[a];
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'h9E3779B9 * 32'(i + 1));
      return l;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 32; s++) begin
         m_last[s] = 0;
         for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
         end
      end
      m_rr = 0;
      exp_q.delete();
      in_x = 1'b0;
      refill_acked = 1'b0;
   endtask

   // Reference behaviour of one CPU access: expected memory traffic plus the read value.
   task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output bit miss);
      int s, w, way;
      logic [21:0] t;
      xfer_t x;
      s = int'(a[9:5]);
      w = int'(a[4:2]);
      t = a[31:10];
      way = -1;
      for (int i = 0; i < 2; i++) if (m_valid[s][i] && m_tag[s][i] == t) way = i;
      miss = (way < 0);
      if (miss) begin
         if (!m_valid[s][0])      way = 0;
         else if (!m_valid[s][1]) way = 1;
         else begin
`ifdef DCACHE_LRU_EN
            way = 1 - m_last[s];
`else
            way = m_rr;
`endif
         end
         if (m_valid[s][way] && m_dirty[s][way]) begin
            x.wr = 1'b1;
            x.addr = {m_tag[s][way], 5'(s), 5'b0};
            x.data = m_line[s][way];
            exp_q.push_back(x);
         end
         x.wr = 1'b0;
         x.addr = {t, 5'(s), 5'b0};
         x.data = mem_get(x.addr);
         exp_q.push_back(x);
         m_line[s][way]  = x.data;
         m_valid[s][way] = 1'b1;
         m_dirty[s][way] = 1'b0;
         m_tag[s][way]   = t;
         m_rr = 1 - m_rr;
      end
      m_last[s] = way;
      rd = 32'h0;
      if (wr) begin
         m_line[s][way][w*32 +: 32] = d;
         m_dirty[s][way] = 1'b1;
      end else begin
         rd = m_line[s][way][w*32 +: 32];
      end
   endtask

   // Acts as the line memory for one sampled cycle; called at the falling edge.
   task automatic mem_service(input int dly);
      if (mem_enable_o) begin
         if (!in_x) begin
            chk("xfer_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            else begin
               cur.wr = mem_write_o;
               cur.addr = mem_addr_o;
               cur.data = '0;
            end
            in_x = 1'b1;
            wt = 0;
            seen++;
            chk("xfer_dir", mem_write_o, cur.wr);
            chk("xfer_addr", mem_addr_o, cur.addr);
            if (cur.wr) chk("xfer_wdata", mem_data_o, cur.data);
         end else begin
            chk("hold_dir", mem_write_o, cur.wr);
            chk("hold_addr", mem_addr_o, cur.addr);
            if (cur.wr) chk("hold_wdata", mem_data_o, cur.data);
         end
         if (wt >= dly) begin
            mem_ack_i = 1'b1;
            mem_data_i = cur.wr ? '0 : cur.data;
            if (cur.wr) begin
               memory[cur.addr] = cur.data;
               last_wb_addr = cur.addr;
               last_wb_data = cur.data;
            end else begin
               refill_acked = 1'b1;
            end
            in_x = 1'b0;
         end else begin
            wt++;
         end
      end else begin
         if (in_x) chk("hold_enable", mem_enable_o, 1);
         chk("idle_mem_write", mem_write_o, 0);
         chk("idle_mem_addr", mem_addr_o, 0);
         chk("idle_mem_data", mem_data_o, 0);
      end
   endtask

   task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input int dly, output logic [31:0] rd_obs);
      logic [31:0] exp_rd;
      bit miss, done;
      int nx;
      model_access(wr, a, d, exp_rd, miss);
      nx = exp_q.size();
      seen = 0;
      done = 1'b0;
      rd_obs = 32'h0;
      p1_addr_i = a;
      p1_data_i = d;
      p1_MemRead_i = !wr;
      p1_MemWrite_i = wr;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (cyc == 0) chk("stall_first", p1_stall_o, miss);
         if (refill_acked) begin
            chk("stall_after_refill", p1_stall_o, 0);
            refill_acked = 1'b0;
         end
         if (!p1_stall_o) begin
            rd_obs = p1_data_o;
            chk("p1_data", p1_data_o, exp_rd);
            chk("hit_mem_enable", mem_enable_o, 0);
            done = 1'b1;
         end else begin
            mem_service(dly);
         end
      end
      chk("access_done", done, 1);
      chk("xfer_count", seen, nx);
      exp_q.delete();
      @(posedge clk_i);
      #1;
      p1_MemRead_i = 1'b0;
      p1_MemWrite_i = 1'b0;
   endtask

   task automatic do_flush(input int dly);
      bit busy_seen, done;
      int nx;
      xfer_t x;
      for (int s = 0; s < 32; s++)
         for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_dirty[s][w]) begin
               x.wr = 1'b1;
               x.addr = {m_tag[s][w], 5'(s), 5'b0};
               x.data = m_line[s][w];
               exp_q.push_back(x);
               m_dirty[s][w] = 1'b0;
            end
      nx = exp_q.size();
      seen = 0;
      busy_seen = 1'b0;
      done = 1'b0;
      flush_i = 1'b1;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (flush_busy_o) begin
            busy_seen = 1'b1;
            flush_i = 1'b0;
            mem_service(dly);
         end else if (busy_seen) begin
            done = 1'b1;
         end
      end
      flush_i = 1'b0;
      chk("flush_busy_seen", busy_seen, 1);
      chk("flush_done", done, 1);
      chk("flush_wb_count", seen, nx);
      chk("flush_stall_after", p1_stall_o, 0);
      exp_q.delete();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      chk("rst_mem_enable", mem_enable_o, 0);
      chk("rst_flush_busy", flush_busy_o, 0);
      chk("rst_stall", p1_stall_o, 0);
      rst_i = 1'b1;
      model_reset();
      @(posedge clk_i);
      #1;
   endtask

   logic [31:0]  rd, addr_r;
   logic [255:0] l0;
   bit           got;

   initial begin
      rst_i = 1'b0;
      p1_addr_i = 32'h40;
      p1_data_i = 32'h0;
      p1_MemRead_i = 1'b1;
      p1_MemWrite_i = 1'b0;
      flush_i = 1'b0;
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      last_wb_addr = 32'h0;
      last_wb_data = '0;
      model_reset();

      @(posedge clk_i);
      @(negedge clk_i);
      chk("reset_stall_with_req", p1_stall_o, 1);
      chk("reset_p1_data", p1_data_o, 0);
      chk("reset_mem_enable", mem_enable_o, 0);
      chk("reset_mem_write", mem_write_o, 0);
      chk("reset_mem_addr", mem_addr_o, 0);
      chk("reset_mem_data", mem_data_o, 0);
      chk("reset_flush_busy", flush_busy_o, 0);
      p1_MemRead_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;

      // cold read miss
      l0 = mem_get(32'h0);
      l0[63:32] = 32'h11111111;
      memory[32'h0] = l0;
      access(1'b0, 32'h0000_0004, 32'h0, 0, rd);
      chk("cold_word1", rd, 32'h11111111);

      // victim choice on a full set
      do_reset();
      access(1'b1, 32'h0000_0400, 32'hDEADBEEF, 1, rd);
      access(1'b1, 32'h0000_0800, 32'h0BADF00D, 0, rd);
      access(1'b0, 32'h0000_0400, 32'h0, 0, rd);
      chk("lru_hit_data", rd, 32'hDEADBEEF);
      access(1'b0, 32'h0000_0C00, 32'h0, 2, rd);
`ifdef DCACHE_LRU_EN
      chk("evict_wb_addr", last_wb_addr, 32'h0000_0800);
`else
      chk("evict_wb_addr", last_wb_addr, 32'h0000_0400);
      chk("evict_wb_word0", last_wb_data[31:0], 32'hDEADBEEF);
`endif

      // read after write
      access(1'b1, 32'h0000_1004, 32'hCAFEF00D, 0, rd);
      access(1'b0, 32'h0000_1004, 32'h0, 0, rd);
      chk("raw_data", rd, 32'hCAFEF00D);

      // flush
      do_reset();
      access(1'b1, 32'h0000_0000, 32'h00000A00, 0, rd);
      access(1'b1, 32'h0000_0020, 32'h00000A20, 0, rd);
      access(1'b1, 32'h0000_0440, 32'h00000A44, 1, rd);
      access(1'b0, 32'h0000_0060, 32'h0, 0, rd);
      do_flush(1);
      chk("flush_wb_total", seen, 3);
      access(1'b0, 32'h0000_0000, 32'h0, 0, rd);
      chk("post_flush_data", rd, 32'h00000A00);

      // slow memory
      access(1'b0, 32'h0000_3140, 32'h0, 10, rd);

      // reset during a writeback
      access(1'b1, 32'h0001_00E0, 32'h11110000, 0, rd);
      access(1'b1, 32'h0001_04E0, 32'h22220000, 0, rd);
      model_access(1'b0, 32'h0001_08E0, 32'h0, rd, got);
      addr_r = exp_q[0].addr;
      p1_addr_i = 32'h0001_08E0;
      p1_MemRead_i = 1'b1;
      got = 1'b0;
      for (int cyc = 0; cyc < 100 && !got; cyc++) begin
         @(negedge clk_i);
         if (mem_enable_o && mem_write_o) begin
            got = 1'b1;
            chk("rst_wb_addr", mem_addr_o, addr_r);
         end
      end
      chk("rst_wb_reached", got, 1);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("midrst_mem_enable", mem_enable_o, 0);
      chk("midrst_flush_busy", flush_busy_o, 0);
      chk("midrst_stall", p1_stall_o, 1);
      chk("midrst_p1_data", p1_data_o, 0);
      chk("midrst_mem_addr", mem_addr_o, 0);
      rst_i = 1'b1;
      p1_MemRead_i = 1'b0;
      model_reset();
      @(posedge clk_i);
      #1;
      access(1'b0, 32'h0001_00E0, 32'h0, 0, rd);

      // random traffic over a few conflicting sets
      for (int i = 0; i < 240; i++) begin
         addr_r = {22'(32'h20 + $urandom_range(0, 3)), 5'(12 + $urandom_range(0, 2)),
                   3'($urandom_range(0, 7)), 2'b00};
         access(1'($urandom_range(0, 1)), addr_r, $urandom, $urandom_range(0, 3), rd);
         if (i % 80 == 79) do_flush($urandom_range(0, 2));
      end
      do_flush(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
